// File: rtl/battle_arena.sv
// ---------------------------------------------------------------------------
// battle_arena
//   Battle-phase engine. Loads two teams of two units from a fixed unit
//   table, then resolves a front-line exchange battle, one exchange per
//   clkBE strobe, and reports the outcome to control and display.
//
//   Optional feature macro: BATTLE_TIMEOUT_EN
//     When defined, a battle that reaches MAX_STRIKES exchanges with both
//     sides still alive ends as a loss. When undefined there is no strike
//     limit.
//
//   Parameters:
//     MAX_STRIKES   strike limit for the timeout (1..31)
//
//   Ports:
//     clk           system clock
//     reset         asynchronous, active-low reset (returns to IDLE)
//     clkBE         one-cycle attack strobe
//     start_battle  one-cycle pulse that starts a battle
//     pet1, pet2    player unit ids (id >= 4 is an empty slot)
//     opp1, opp2    opponent unit ids (id >= 4 is an empty slot)
//     busy          high in LOAD, FIGHT and CHECK
//     battleDone    high while in DONE
//     battleWin     outcome, valid while battleDone is high, else 0
//     *_status      remaining HP per unit (0 = dead or empty)
//     strikes       exchanges in the current battle, saturating at 31
// ---------------------------------------------------------------------------
module battle_arena #(
    parameter int MAX_STRIKES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkBE,
    input  logic       start_battle,
    input  logic [2:0] pet1,
    input  logic [2:0] pet2,
    input  logic [2:0] opp1,
    input  logic [2:0] opp2,
    output logic       busy,
    output logic       battleDone,
    output logic       battleWin,
    output logic [2:0] pet1_status,
    output logic [2:0] pet2_status,
    output logic [2:0] opp1_status,
    output logic [2:0] opp2_status,
    output logic [4:0] strikes
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FIGHT = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

`ifdef BATTLE_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif
    localparam logic [4:0] STRIKE_LIM = 5'(MAX_STRIKES);

    function automatic logic [2:0] unit_atk(input logic [2:0] id);
        case (id)
            3'd0:    return 3'd2;
            3'd1:    return 3'd3;
            3'd2:    return 3'd1;
            3'd3:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] unit_hp(input logic [2:0] id);
        case (id)
            3'd0:    return 3'd3;
            3'd1:    return 3'd2;
            3'd2:    return 3'd5;
            3'd3:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Damage never wraps below zero.
    function automatic logic [2:0] sat_sub(input logic [2:0] hp, input logic [2:0] atk);
        return (hp > atk) ? (hp - atk) : 3'd0;
    endfunction

    state_t     state_q, state_d;
    logic       first_q;
    logic [2:0] pid1_q, pid2_q, oid1_q, oid2_q;
    logic [2:0] p1_hp_q, p2_hp_q, o1_hp_q, o2_hp_q;
    logic [4:0] strikes_q;
    logic       busy_q, done_q, win_q;
    logic       busy_d, done_d, win_d;

    logic       p_alive, o_alive, timeout_hit, strike;
    logic       p1_front, o1_front;
    logic [2:0] p_atk, o_atk;

    assign p_alive     = |{p1_hp_q, p2_hp_q};
    assign o_alive     = |{o1_hp_q, o2_hp_q};
    assign timeout_hit = TIMEOUT_EN && (strikes_q == STRIKE_LIM);

    // The first FIGHT cycle after LOAD only passes through to CHECK so that
    // empty teams resolve without an exchange.
    assign strike   = (state_q == S_FIGHT) && clkBE && !first_q;

    assign p1_front = (p1_hp_q != 3'd0);
    assign o1_front = (o1_hp_q != 3'd0);
    assign p_atk    = p1_front ? unit_atk(pid1_q) : unit_atk(pid2_q);
    assign o_atk    = o1_front ? unit_atk(oid1_q) : unit_atk(oid2_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_battle) state_d = S_LOAD;
            S_LOAD:  state_d = S_FIGHT;
            S_FIGHT: if (first_q || clkBE) state_d = S_CHECK;
            S_CHECK: state_d = (!p_alive || !o_alive || timeout_hit) ? S_DONE : S_FIGHT;
            S_DONE:  if (start_battle) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic, computed from the next state so the flags are registered
    always_comb begin
        busy_d = (state_d == S_LOAD) || (state_d == S_FIGHT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        win_d  = 1'b0;
        if (state_q == S_CHECK && state_d == S_DONE) begin
            // A wipe outranks the timeout; a mutual wipe is a loss.
            win_d = p_alive && !o_alive;
        end else if (state_d == S_DONE) begin
            win_d = win_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            win_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            win_q  <= win_d;
        end
    end

    // Unit table load and exchange datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_q   <= 1'b0;
            pid1_q    <= 3'd0;
            pid2_q    <= 3'd0;
            oid1_q    <= 3'd0;
            oid2_q    <= 3'd0;
            p1_hp_q   <= 3'd0;
            p2_hp_q   <= 3'd0;
            o1_hp_q   <= 3'd0;
            o2_hp_q   <= 3'd0;
            strikes_q <= 5'd0;
        end else if (state_q == S_LOAD) begin
            first_q   <= 1'b1;
            pid1_q    <= pet1;
            pid2_q    <= pet2;
            oid1_q    <= opp1;
            oid2_q    <= opp2;
            p1_hp_q   <= unit_hp(pet1);
            p2_hp_q   <= unit_hp(pet2);
            o1_hp_q   <= unit_hp(opp1);
            o2_hp_q   <= unit_hp(opp2);
            strikes_q <= 5'd0;
        end else if (state_q == S_FIGHT) begin
            first_q <= 1'b0;
            if (strike) begin
                if (p1_front) p1_hp_q <= sat_sub(p1_hp_q, o_atk);
                else          p2_hp_q <= sat_sub(p2_hp_q, o_atk);
                if (o1_front) o1_hp_q <= sat_sub(o1_hp_q, p_atk);
                else          o2_hp_q <= sat_sub(o2_hp_q, p_atk);
                if (strikes_q != 5'd31) strikes_q <= strikes_q + 5'd1;
            end
        end
    end

    assign busy        = busy_q;
    assign battleDone  = done_q;
    assign battleWin   = win_q;
    assign pet1_status = p1_hp_q;
    assign pet2_status = p2_hp_q;
    assign opp1_status = o1_hp_q;
    assign opp2_status = o2_hp_q;
    assign strikes     = strikes_q;

endmodule

// File: tb/tb_battle_arena.sv
module tb_battle_arena;

    localparam int MAXS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clkBE;
    logic       start_battle;
    logic [2:0] pet1, pet2, opp1, opp2;
    logic       busy, battleDone, battleWin;
    logic [2:0] pet1_status, pet2_status, opp1_status, opp2_status;
    logic [4:0] strikes;

    always #5 clk = ~clk;

    battle_arena #(.MAX_STRIKES(MAXS)) dut (
        .clk          (clk),
        .reset        (reset),
        .clkBE        (clkBE),
        .start_battle (start_battle),
        .pet1         (pet1),
        .pet2         (pet2),
        .opp1         (opp1),
        .opp2         (opp2),
        .busy         (busy),
        .battleDone   (battleDone),
        .battleWin    (battleWin),
        .pet1_status  (pet1_status),
        .pet2_status  (pet2_status),
        .opp1_status  (opp1_status),
        .opp2_status  (opp2_status),
        .strikes      (strikes)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural reference: unit table and battle state as plain integers.
    // Index 0/1 = pet1/pet2, 2/3 = opp1/opp2.
    int atk_tab [8] = '{2, 3, 1, 2, 0, 0, 0, 0};
    int hp_tab  [8] = '{3, 2, 5, 4, 0, 0, 0, 0};
    int m_hp  [4];
    int m_atk [4];
    int m_strikes;
    bit m_done;
    bit m_win;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_load(input int a, input int b, input int c, input int d);
        int ids [4];
        ids = '{a, b, c, d};
        foreach (ids[k]) begin
            m_hp[k]  = hp_tab[ids[k]];
            m_atk[k] = atk_tab[ids[k]];
        end
        m_strikes = 0;
    endtask

    task automatic model_strike();
        int pf, of, np, no;
        pf = (m_hp[0] > 0) ? 0 : 1;
        of = (m_hp[2] > 0) ? 2 : 3;
        np = m_hp[pf] - m_atk[of];
        no = m_hp[of] - m_atk[pf];
        m_hp[pf] = (np < 0) ? 0 : np;
        m_hp[of] = (no < 0) ? 0 : no;
        m_strikes = (m_strikes >= 31) ? 31 : m_strikes + 1;
    endtask

    task automatic model_resolve();
        bit p, o;
        p = (m_hp[0] + m_hp[1]) > 0;
        o = (m_hp[2] + m_hp[3]) > 0;
        m_done = !p || !o;
        m_win  = p && !o;
`ifdef BATTLE_TIMEOUT_EN
        if (!m_done && m_strikes == MAXS) begin
            m_done = 1'b1;
            m_win  = 1'b0;
        end
`endif
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_pet1"}, pet1_status, m_hp[0]);
        chk({tag, "_pet2"}, pet2_status, m_hp[1]);
        chk({tag, "_opp1"}, opp1_status, m_hp[2]);
        chk({tag, "_opp2"}, opp2_status, m_hp[3]);
        chk({tag, "_strikes"}, strikes, m_strikes);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, battleDone, 0);
        chk({tag, "_win"}, battleWin, 0);
        chk({tag, "_pet1"}, pet1_status, 0);
        chk({tag, "_pet2"}, pet2_status, 0);
        chk({tag, "_opp1"}, opp1_status, 0);
        chk({tag, "_opp2"}, opp2_status, 0);
        chk({tag, "_strikes"}, strikes, 0);
    endtask

    // Runs one complete battle from IDLE or DONE and leaves the DUT in DONE.
    // rnd adds dropped strobes, ignored start pulses, id churn and idle gaps.
    task automatic run_battle(input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] c, input logic [2:0] d, input bit rnd);
        int n;
        pet1 = a; pet2 = b; opp1 = c; opp2 = d;
        start_battle = 1'b1;
        tick();                                   // t+1: LOAD
        start_battle = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_done", battleDone, 0);
        clkBE = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();                                   // t+2: FIGHT, statuses loaded
        clkBE = 1'b0;
        model_load(a, b, c, d);
        check_status("load");
        chk("fight_busy", busy, 1);
        if (rnd) begin
            pet1 = 3'($urandom_range(0, 7)); pet2 = 3'($urandom_range(0, 7));
            opp1 = 3'($urandom_range(0, 7)); opp2 = 3'($urandom_range(0, 7));
        end
        tick();                                   // t+3: CHECK
        tick();                                   // t+4: DONE or FIGHT
        model_resolve();
        chk("entry_done", battleDone, m_done);
        chk("entry_win", battleWin, m_win);
        n = 0;
        while (!m_done && n < 40) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    start_battle = 1'($urandom_range(0, 1));
                    tick();
                    start_battle = 1'b0;
                    chk("idle_busy", busy, 1);
                    chk("idle_done", battleDone, 0);
                end
            end
            clkBE = 1'b1;
            tick();                               // s+1: CHECK
            clkBE = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            model_strike();
            check_status("strike");
            tick();                               // s+2: DONE or FIGHT
            clkBE = 1'b0;
            model_resolve();
            chk("strike_done", battleDone, m_done);
            chk("strike_win", battleWin, m_win);
            n++;
        end
        if (n >= 40) chk("battle_budget", battleDone, 1);
        clkBE = 1'b1;
        tick();
        clkBE = 1'b0;
        tick();
        check_status("frozen");
        chk("frozen_done", battleDone, 1);
        chk("frozen_win", battleWin, m_win);
        chk("frozen_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b0; clkBE = 1'b0; start_battle = 1'b0;
        pet1 = 3'd0; pet2 = 3'd0; opp1 = 3'd0; opp2 = 3'd0;
        tick();
        tick();
        check_zero("reset");
        reset = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // clkBE in IDLE is ignored
        clkBE = 1'b1;
        tick();
        clkBE = 1'b0;
        check_zero("idle_strobe");

        // Reset mid-FIGHT takes effect without a clock edge
        pet1 = 3'd0; pet2 = 3'd1; opp1 = 3'd2; opp2 = 3'd3;
        start_battle = 1'b1;
        tick();
        start_battle = 1'b0;
        tick();
        tick();
        tick();
        clkBE = 1'b1;
        tick();
        clkBE = 1'b0;
        tick();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        tick();
        reset = 1'b1;
        tick();
        check_zero("post_reset");

        // Single-strike win
        run_battle(3'd3, 3'd4, 3'd1, 3'd4, 1'b0);
        chk("single_pet1", pet1_status, 1);
        chk("single_opp1", opp1_status, 0);
        chk("single_strikes", strikes, 1);
        chk("single_win", battleWin, 1);

        // Mutual wipe is a loss
        run_battle(3'd0, 3'd7, 3'd2, 3'd7, 1'b0);
        chk("wipe_pet1", pet1_status, 0);
        chk("wipe_opp1", opp1_status, 0);
        chk("wipe_strikes", strikes, 3);
        chk("wipe_win", battleWin, 0);

        // Front-line switch / timeout
        run_battle(3'd2, 3'd3, 3'd2, 3'd4, 1'b0);
`ifdef BATTLE_TIMEOUT_EN
        chk("timeout_strikes", strikes, 4);
        chk("timeout_pet1", pet1_status, 1);
        chk("timeout_opp1", opp1_status, 1);
        chk("timeout_win", battleWin, 0);
`else
        chk("switch_strikes", strikes, 5);
        chk("switch_pet1", pet1_status, 0);
        chk("switch_opp1", opp1_status, 0);
        chk("switch_pet2", pet2_status, 4);
        chk("switch_win", battleWin, 1);
`endif

        // Both teams empty: done and lost at t+4
        run_battle(3'd4, 3'd5, 3'd6, 3'd7, 1'b0);
        chk("empty_done", battleDone, 1);
        chk("empty_win", battleWin, 0);
        chk("empty_strikes", strikes, 0);

        // Randomized battles, each restarted from DONE
        for (int i = 0; i < 24; i++) begin
            run_battle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/battle_arena.md
# battle_arena

Battle-phase engine that sits directly downstream of the datapath. It consumes the team ids (`pet1`, `pet2`, `opp1`, `opp2`) and the `clkBE` attack strobe. It resolves a front-line exchange battle and returns `battleDone`, `battleWin` and per-unit remaining HP to the control FSM and the display logic. All outputs are registered.

## Interface
- `MAX_STRIKES`, default 8: strike limit used only when the timeout is compiled in; range 1..31.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low; returns the block to IDLE.
- `clkBE` input 1: one-cycle attack strobe; one exchange per strobe.
- `start_battle` input 1: one-cycle pulse from control on entry to the battle state.
- `pet1`, `pet2`, `opp1`, `opp2` input 3 each: unit ids; any id ≥4 is an empty slot.
- `busy` output 1: high in LOAD, FIGHT and CHECK.
- `battleDone` output 1: high while in DONE.
- `battleWin` output 1: valid while `battleDone` is high; 0 otherwise.
- `pet1_status`, `pet2_status`, `opp1_status`, `opp2_status` output 3 each: remaining HP; 0 means dead or empty.
- `strikes` output 5: number of exchanges in the current battle; saturates at 31.

## Operation
- **Unit table:**
  - id0: atk 2, hp 3
  - id1: atk 3, hp 2
  - id2: atk 1, hp 5
  - id3: atk 2, hp 4
  - id≥4: atk 0, hp 0
- **States:** IDLE, LOAD, FIGHT, CHECK, DONE.
- **IDLE:**
  - `start_battle` → LOAD.
  - `clkBE` is ignored.
- **LOAD (1 cycle):**
  - Latch ids and load HP from the table into the four status registers.
  - Clear `strikes` to 0.
  - → FIGHT.
- **Front units:**
  - Player front = pet1 if `pet1_status`≠0, else pet2.
  - Opponent front = opp1 if `opp1_status`≠0, else opp2.
- **FIGHT:**
  - On `clkBE`, both fronts damage each other simultaneously; each HP becomes max(hp − enemy atk, 0).
  - `strikes` increments on each such strobe.
  - After a strobe → CHECK.
  - Without a strobe, remain in FIGHT.
  - On entry from LOAD, FIGHT first goes to CHECK without a strike, so that empty teams are resolved.
- **CHECK (1 cycle):**
  - P = player has any HP>0; O = opponent has any HP>0.
  - !P or !O → DONE, with `battleWin` = P & !O. Mutual wipe is a loss.
  - Otherwise → FIGHT.
  - A `clkBE` that arrives during CHECK, LOAD or DONE is dropped.
- **DONE:**
  - `battleDone`=1 and `battleWin` is held.
  - Status registers freeze.
  - `start_battle` → LOAD, which starts a new battle.
- **`start_battle` in FIGHT or CHECK:** ignored.
- **Id inputs:** only sampled in LOAD; changes mid-battle have no effect.
- **Arithmetic:** HP and atk are 3-bit unsigned; subtraction saturates at 0 and never wraps.

## Timing
- **Reset values:**
  - State IDLE.
  - All status outputs 0, `strikes` 0.
  - `busy`, `battleDone` and `battleWin` all 0.
- **Reset asserted mid-battle:** immediate return to IDLE and all outputs to reset values; no `battleDone` is emitted.
- **Start latency:** `start_battle` at cycle t → LOAD at t+1 → FIGHT at t+2, with statuses valid from t+2.
- **Strike latency:**
  - `clkBE` at cycle s in FIGHT → updated statuses and `strikes` visible at s+1, in CHECK.
  - `battleDone` high at s+2 if the battle ended.
- **Strobe spacing:** strobes must be spaced ≥2 cycles apart; closer strobes lose one exchange.
- **Empty teams:** both teams empty → `battleDone`=1, `battleWin`=0 at t+4.

## Configuration
- Macro: `BATTLE_TIMEOUT_EN`.
- **Defined:**
  - In CHECK, if `strikes` == `MAX_STRIKES` and neither side is wiped → DONE with `battleWin`=0.
  - A wipe takes priority over the timeout on the same CHECK.
- **Undefined:**
  - There is no strike limit, and `MAX_STRIKES` is unused.
  - Every battle terminates anyway, because every live unit has atk ≥1.

## Test plan
- **Reset:** drive `reset` low mid-FIGHT → all outputs 0 and state IDLE on the same edge; a following `start_battle` reloads normally.
- **Single-strike win:** pet1=3, pet2=4, opp1=1, opp2=4, one `clkBE` → `pet1_status`=1, `opp1_status`=0, `strikes`=1, `battleDone`=1 and `battleWin`=1 two cycles after the strobe.
- **Mutual wipe:** pet1=0 vs opp1=2, other slots empty, 3 strobes → statuses 2/1/0 vs 3/1/0, `battleWin`=0.
- **Front-line switch, timeout not defined:** pet1=2, pet2=3 vs opp1=2, opp2=4.
  - After 5 strobes, pet1 and opp1 are both 0 and pet2 is 4.
  - `battleWin`=1.
- **Timeout defined:** same team with `MAX_STRIKES`=4 → after 4 strobes `battleDone`=1, `battleWin`=0, `pet1_status`=1, `opp1_status`=1.
- **Dropped inputs:**
  - A `clkBE` during CHECK does not change `strikes`.
  - Both teams empty → done with `battleWin`=0 at t+4.
  - `start_battle` in DONE restarts with fresh HP.
